// File: rtl/memory_stage_if.sv
// Execute-to-memory handshake, data SRAM load port and memory-to-writeback outputs.
// The slave modport is the memory stage; the master modport is its surroundings.
interface memory_stage_if;
  logic        exe_valid;
  logic        exe_reg_en;
  logic        exe_mem_read;
  logic [5:0]  exe_reg_waddr;
  logic [31:0] alu_result;
  logic [31:0] alu_result_reg;
  logic        exe_double_en;
  logic        exe_is_div;
  logic [31:0] exe_HI_wdata;
  logic [31:0] exe_LO_wdata;
  logic        div_complete;
  logic        wb_allowin;
  logic [31:0] data_sram_rdata;
  logic        mem_allowin;
  logic        data_sram_en;
  logic [31:0] data_sram_addr;
  logic        mem_out_valid;
  logic        mem_reg_en;
  logic [5:0]  mem_reg_waddr;
  logic [31:0] mem_reg_wdata;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  modport slave (
    input  exe_valid, exe_reg_en, exe_mem_read, exe_reg_waddr, alu_result, alu_result_reg,
           exe_double_en, exe_is_div, exe_HI_wdata, exe_LO_wdata, div_complete, wb_allowin,
           data_sram_rdata,
    output mem_allowin, data_sram_en, data_sram_addr, mem_out_valid, mem_reg_en,
           mem_reg_waddr, mem_reg_wdata, hi_out, lo_out
  );

  modport master (
    output exe_valid, exe_reg_en, exe_mem_read, exe_reg_waddr, alu_result, alu_result_reg,
           exe_double_en, exe_is_div, exe_HI_wdata, exe_LO_wdata, div_complete, wb_allowin,
           data_sram_rdata,
    input  mem_allowin, data_sram_en, data_sram_addr, mem_out_valid, mem_reg_en,
           mem_reg_waddr, mem_reg_wdata, hi_out, lo_out
  );
endinterface

// File: rtl/memory_stage.sv
// Memory pipeline stage: issues loads, forwards GPR results to writeback and owns HI/LO,
// stalling in StDivWait until the divider reports completion.
module memory_stage (
  input  logic           clk,
  input  logic           resetn,
  memory_stage_if.slave  bus
);

  typedef enum logic [0:0] {StRun, StDivWait} state_e;

  state_e      state_q, state_d;
  logic        mem_valid_q, mem_valid_d;
  logic        reg_en_q, reg_en_d;
  logic        mem_read_q, mem_read_d;
  logic [5:0]  reg_waddr_q, reg_waddr_d;
  logic [31:0] alu_result_reg_q, alu_result_reg_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic run;
  logic allowin;
  logic accept;

  assign run     = (state_q == StRun);
  assign allowin = !mem_valid_q || (bus.wb_allowin && run);
  assign accept  = bus.exe_valid && allowin;

  assign bus.mem_allowin    = allowin;
  assign bus.data_sram_en   = accept && bus.exe_mem_read;
  assign bus.data_sram_addr = bus.alu_result;
  assign bus.mem_out_valid  = mem_valid_q && run;
  assign bus.mem_reg_en     = reg_en_q;
  assign bus.mem_reg_waddr  = reg_waddr_q;
  assign bus.mem_reg_wdata  = mem_read_q ? bus.data_sram_rdata : alu_result_reg_q;
  assign bus.hi_out         = hi_q;
  assign bus.lo_out         = lo_q;

  always_comb begin
    state_d          = state_q;
    mem_valid_d      = mem_valid_q;
    reg_en_d         = reg_en_q;
    mem_read_d       = mem_read_q;
    reg_waddr_d      = reg_waddr_q;
    alu_result_reg_d = alu_result_reg_q;
    hi_d             = hi_q;
    lo_d             = lo_q;

    if (accept) begin
      mem_valid_d      = 1'b1;
      reg_en_d         = bus.exe_reg_en;
      mem_read_d       = bus.exe_mem_read;
      reg_waddr_d      = bus.exe_reg_waddr;
      alu_result_reg_d = bus.alu_result_reg;
      // A divide that finishes in its own accept cycle never needs to wait.
      if (bus.exe_double_en) begin
        if (!bus.exe_is_div || bus.div_complete) begin
          hi_d = bus.exe_HI_wdata;
          lo_d = bus.exe_LO_wdata;
        end else begin
          state_d = StDivWait;
        end
      end
    end else if (mem_valid_q && bus.wb_allowin && run) begin
      mem_valid_d = 1'b0;
    end

    // accept is impossible here: the waiting divide keeps mem_valid_q set.
    if (state_q == StDivWait && bus.div_complete) begin
      hi_d    = bus.exe_HI_wdata;
      lo_d    = bus.exe_LO_wdata;
      state_d = StRun;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q          <= StRun;
      mem_valid_q      <= 1'b0;
      reg_en_q         <= 1'b0;
      mem_read_q       <= 1'b0;
      reg_waddr_q      <= 6'd0;
      alu_result_reg_q <= 32'd0;
      hi_q             <= 32'd0;
      lo_q             <= 32'd0;
    end else begin
      state_q          <= state_d;
      mem_valid_q      <= mem_valid_d;
      reg_en_q         <= reg_en_d;
      mem_read_q       <= mem_read_d;
      reg_waddr_q      <= reg_waddr_d;
      alu_result_reg_q <= alu_result_reg_d;
      hi_q             <= hi_d;
      lo_q             <= lo_d;
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage; writeback results are tracked in a scoreboard queue.
module tb_memory_stage;

  logic clk;
  logic resetn;
  int   checks;
  int   errors;

  typedef struct packed {
    logic        en;
    logic [5:0]  waddr;
    logic [31:0] wdata;
  } wb_t;

  wb_t sb[$];
  wb_t exp_wb;
  wb_t got_wb;

  memory_stage_if mif();

  memory_stage u_dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (mif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign got_wb = '{en: mif.mem_reg_en, waddr: mif.mem_reg_waddr, wdata: mif.mem_reg_wdata};

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    mif.exe_valid       = 1'b0;
    mif.exe_reg_en      = 1'b0;
    mif.exe_mem_read    = 1'b0;
    mif.exe_reg_waddr   = 6'd0;
    mif.alu_result      = 32'd0;
    mif.alu_result_reg  = 32'd0;
    mif.exe_double_en   = 1'b0;
    mif.exe_is_div      = 1'b0;
    mif.exe_HI_wdata    = 32'd0;
    mif.exe_LO_wdata    = 32'd0;
    mif.div_complete    = 1'b0;
    mif.wb_allowin      = 1'b1;
    mif.data_sram_rdata = 32'd0;
  endtask

  task automatic drive_op(input logic [5:0] waddr, input logic [31:0] res, input logic rd);
    mif.exe_valid      = 1'b1;
    mif.exe_reg_en     = 1'b1;
    mif.exe_mem_read   = rd;
    mif.exe_reg_waddr  = waddr;
    mif.alu_result     = res;
    mif.alu_result_reg = res;
    mif.exe_double_en  = 1'b0;
    mif.exe_is_div     = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    mif.exe_valid = 1'b1;
    #1;
    checks++;
    if ({mif.mem_out_valid, got_wb, mif.hi_out, mif.lo_out} !== '0) begin
      errors++;
      $display("FAIL reset_state got valid=%b wb=%h hi=%h lo=%h exp all zero",
               mif.mem_out_valid, got_wb, mif.hi_out, mif.lo_out);
    end
    @(negedge clk);
    mif.exe_valid = 1'b0;
    resetn = 1'b1;
    #1;
    checks++;
    if (mif.mem_allowin !== 1'b1 || mif.mem_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset got allowin=%b valid=%b exp 1 0", mif.mem_allowin,
               mif.mem_out_valid);
    end
  endtask

  task automatic test_alu();
    drive_op(6'd5, 32'h1234, 1'b0);
    sb.push_back('{en: 1'b1, waddr: 6'd5, wdata: 32'h1234});
    step();
    idle();
    #1;
    checks++;
    if (mif.mem_out_valid !== 1'b1 || sb.size() == 0) begin
      errors++;
      $display("FAIL alu_valid got %b exp 1 (sb size %0d)", mif.mem_out_valid, sb.size());
    end else begin
      exp_wb = sb.pop_front();
      if (got_wb !== exp_wb) begin
        errors++;
        $display("FAIL alu_out got %h exp %h", got_wb, exp_wb);
      end
    end
    step();
    checks++;
    if (mif.mem_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL alu_drain got valid=%b exp 0", mif.mem_out_valid);
    end
  endtask

  task automatic test_load();
    drive_op(6'd7, 32'h100, 1'b1);
    #1;
    checks++;
    if (mif.data_sram_en !== 1'b1 || mif.data_sram_addr !== 32'h100) begin
      errors++;
      $display("FAIL load_req got en=%b addr=%h exp 1 00000100", mif.data_sram_en,
               mif.data_sram_addr);
    end
    sb.push_back('{en: 1'b1, waddr: 6'd7, wdata: 32'hDEADBEEF});
    step();
    idle();
    mif.data_sram_rdata = 32'hDEADBEEF;
    #1;
    checks++;
    if (mif.mem_out_valid !== 1'b1 || mif.data_sram_en !== 1'b0 || sb.size() == 0) begin
      errors++;
      $display("FAIL load_valid got valid=%b en=%b exp 1 0", mif.mem_out_valid,
               mif.data_sram_en);
    end else begin
      exp_wb = sb.pop_front();
      if (got_wb !== exp_wb) begin
        errors++;
        $display("FAIL load_out got %h exp %h", got_wb, exp_wb);
      end
    end
    step();
  endtask

  task automatic test_mult();
    mif.exe_valid      = 1'b1;
    mif.exe_double_en  = 1'b1;
    mif.exe_is_div     = 1'b0;
    mif.exe_HI_wdata   = 32'h1;
    mif.exe_LO_wdata   = 32'h2;
    mif.alu_result_reg = 32'hAAAA;
    sb.push_back('{en: 1'b0, waddr: 6'd0, wdata: 32'hAAAA});
    step();
    idle();
    #1;
    checks++;
    if (mif.hi_out !== 32'h1 || mif.lo_out !== 32'h2) begin
      errors++;
      $display("FAIL mult_hilo got %h %h exp 00000001 00000002", mif.hi_out, mif.lo_out);
    end
    checks++;
    if (mif.mem_out_valid !== 1'b1 || sb.size() == 0) begin
      errors++;
      $display("FAIL mult_valid got %b exp 1", mif.mem_out_valid);
    end else begin
      exp_wb = sb.pop_front();
      if (got_wb !== exp_wb) begin
        errors++;
        $display("FAIL mult_out got %h exp %h", got_wb, exp_wb);
      end
    end
    step();
  endtask

  // Divide completing 10 cycles after accept, then back-to-back drain and accept.
  task automatic test_div();
    drive_op(6'd9, 32'h55, 1'b0);
    mif.exe_double_en = 1'b1;
    mif.exe_is_div    = 1'b1;
    sb.push_back('{en: 1'b1, waddr: 6'd9, wdata: 32'h55});
    step();
    drive_op(6'd10, 32'h66, 1'b0);
    mif.exe_HI_wdata = 32'hBAD0;
    mif.exe_LO_wdata = 32'hBAD1;
    for (int i = 0; i < 10; i++) begin
      if (i == 9) begin
        mif.div_complete = 1'b1;
        mif.exe_HI_wdata = 32'h7;
        mif.exe_LO_wdata = 32'h3;
      end
      #1;
      checks++;
      if (mif.mem_allowin !== 1'b0 || mif.mem_out_valid !== 1'b0 ||
          mif.hi_out !== 32'h1 || mif.lo_out !== 32'h2) begin
        errors++;
        $display("FAIL div_wait[%0d] got allowin=%b valid=%b hi=%h lo=%h exp 0 0 1 2", i,
                 mif.mem_allowin, mif.mem_out_valid, mif.hi_out, mif.lo_out);
      end
      step();
    end
    mif.div_complete = 1'b0;
    #1;
    checks++;
    if (mif.hi_out !== 32'h7 || mif.lo_out !== 32'h3 || mif.mem_allowin !== 1'b1) begin
      errors++;
      $display("FAIL div_done got hi=%h lo=%h allowin=%b exp 7 3 1", mif.hi_out, mif.lo_out,
               mif.mem_allowin);
    end
    checks++;
    if (mif.mem_out_valid !== 1'b1 || sb.size() == 0) begin
      errors++;
      $display("FAIL div_valid got %b exp 1", mif.mem_out_valid);
    end else begin
      exp_wb = sb.pop_front();
      if (got_wb !== exp_wb) begin
        errors++;
        $display("FAIL div_out got %h exp %h", got_wb, exp_wb);
      end
    end
    // exe_valid still held: this edge drains the divide and accepts waddr 10.
    sb.push_back('{en: 1'b1, waddr: 6'd10, wdata: 32'h66});
    step();
    idle();
    #1;
    checks++;
    if (mif.mem_out_valid !== 1'b1 || sb.size() == 0) begin
      errors++;
      $display("FAIL b2b_valid got %b exp 1", mif.mem_out_valid);
    end else begin
      exp_wb = sb.pop_front();
      if (got_wb !== exp_wb) begin
        errors++;
        $display("FAIL b2b_out got %h exp %h", got_wb, exp_wb);
      end
    end
    step();
    checks++;
    if (mif.mem_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain got valid=%b exp 0", mif.mem_out_valid);
    end
  endtask

  task automatic test_back_pressure();
    mif.wb_allowin = 1'b0;
    drive_op(6'd3, 32'h33, 1'b0);
    sb.push_back('{en: 1'b1, waddr: 6'd3, wdata: 32'h33});
    step();
    drive_op(6'd4, 32'h400, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (mif.mem_allowin !== 1'b0 || mif.data_sram_en !== 1'b0 || mif.mem_out_valid !== 1'b1 ||
          got_wb !== '{en: 1'b1, waddr: 6'd3, wdata: 32'h33}) begin
        errors++;
        $display("FAIL bp_hold[%0d] got allowin=%b en=%b valid=%b wb=%h exp 0 0 1 held", i,
                 mif.mem_allowin, mif.data_sram_en, mif.mem_out_valid, got_wb);
      end
      step();
    end
    mif.wb_allowin = 1'b1;
    #1;
    checks++;
    if (mif.mem_allowin !== 1'b1 || mif.data_sram_en !== 1'b1 || sb.size() == 0) begin
      errors++;
      $display("FAIL bp_release got allowin=%b en=%b exp 1 1", mif.mem_allowin,
               mif.data_sram_en);
    end else begin
      exp_wb = sb.pop_front();
      if (got_wb !== exp_wb) begin
        errors++;
        $display("FAIL bp_out got %h exp %h", got_wb, exp_wb);
      end
    end
    sb.push_back('{en: 1'b1, waddr: 6'd4, wdata: 32'h4444_0000});
    step();
    idle();
    mif.data_sram_rdata = 32'h4444_0000;
    #1;
    checks++;
    if (mif.mem_out_valid !== 1'b1 || sb.size() == 0) begin
      errors++;
      $display("FAIL bp_next_valid got %b exp 1", mif.mem_out_valid);
    end else begin
      exp_wb = sb.pop_front();
      if (got_wb !== exp_wb) begin
        errors++;
        $display("FAIL bp_next_out got %h exp %h", got_wb, exp_wb);
      end
    end
    step();
  endtask

  task automatic test_div_ignore();
    mif.div_complete = 1'b1;
    mif.exe_HI_wdata = 32'hFF;
    mif.exe_LO_wdata = 32'hEE;
    step();
    drive_op(6'd12, 32'hC, 1'b0);
    mif.div_complete = 1'b1;
    mif.exe_HI_wdata = 32'hFF;
    mif.exe_LO_wdata = 32'hEE;
    sb.push_back('{en: 1'b1, waddr: 6'd12, wdata: 32'hC});
    step();
    #1;
    checks++;
    if (mif.hi_out !== 32'h7 || mif.lo_out !== 32'h3) begin
      errors++;
      $display("FAIL div_ignore got hi=%h lo=%h exp 7 3", mif.hi_out, mif.lo_out);
    end
    if (sb.size() != 0) exp_wb = sb.pop_front();
    checks++;
    if (got_wb !== exp_wb || mif.mem_out_valid !== 1'b1) begin
      errors++;
      $display("FAIL ignore_out got %h valid=%b exp %h 1", got_wb, mif.mem_out_valid, exp_wb);
    end
    // Divide that completes in its own accept cycle.
    drive_op(6'd13, 32'hD, 1'b0);
    mif.exe_double_en = 1'b1;
    mif.exe_is_div    = 1'b1;
    mif.div_complete  = 1'b1;
    mif.exe_HI_wdata  = 32'h11;
    mif.exe_LO_wdata  = 32'h22;
    sb.push_back('{en: 1'b1, waddr: 6'd13, wdata: 32'hD});
    step();
    idle();
    #1;
    checks++;
    if (mif.hi_out !== 32'h11 || mif.lo_out !== 32'h22 || mif.mem_out_valid !== 1'b1) begin
      errors++;
      $display("FAIL div_same_cycle got hi=%h lo=%h valid=%b exp 11 22 1", mif.hi_out,
               mif.lo_out, mif.mem_out_valid);
    end
    if (sb.size() != 0) exp_wb = sb.pop_front();
    checks++;
    if (got_wb !== exp_wb) begin
      errors++;
      $display("FAIL same_cycle_out got %h exp %h", got_wb, exp_wb);
    end
    step();
  endtask

  task automatic test_reset_div();
    drive_op(6'd20, 32'h20, 1'b0);
    mif.exe_double_en = 1'b1;
    mif.exe_is_div    = 1'b1;
    step();
    idle();
    #1;
    checks++;
    if (mif.mem_out_valid !== 1'b0 || mif.mem_allowin !== 1'b0) begin
      errors++;
      $display("FAIL rst_div_wait got valid=%b allowin=%b exp 0 0", mif.mem_out_valid,
               mif.mem_allowin);
    end
    #1;
    resetn = 1'b0;
    #1;
    checks++;
    if (mif.hi_out !== 32'h0 || mif.lo_out !== 32'h0 || mif.mem_allowin !== 1'b1) begin
      errors++;
      $display("FAIL rst_async got hi=%h lo=%h allowin=%b exp 0 0 1", mif.hi_out, mif.lo_out,
               mif.mem_allowin);
    end
    @(negedge clk);
    resetn = 1'b1;
    mif.div_complete = 1'b1;
    mif.exe_HI_wdata = 32'h99;
    mif.exe_LO_wdata = 32'h98;
    step();
    step();
    #1;
    checks++;
    if (mif.hi_out !== 32'h0 || mif.lo_out !== 32'h0 || mif.mem_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_abandon got hi=%h lo=%h valid=%b exp 0 0 0", mif.hi_out, mif.lo_out,
               mif.mem_out_valid);
    end
    idle();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    resetn = 1'b0;
    idle();
    repeat (2) @(negedge clk);
    test_reset();
    test_alu();
    test_load();
    test_mult();
    test_div();
    test_back_pressure();
    test_div_ignore();
    test_reset_div();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_empty got %0d entries exp 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
